// File: rtl/sha_acc_mc.sv
// Multi-channel Avalon-MM register front end for external SHA-256 compression cores.
// Each channel owns a block buffer, control/status flags, a digest register and an IDLE/BUSY/DONE FSM.
module sha_acc_mc #(
   parameter int NUM_CH = 4,
   parameter int AW     = $clog2(NUM_CH) + 5
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    chipselect,
   input  logic                    write,
   input  logic                    read,
   input  logic [AW-1:0]           address,
   input  logic [31:0]             writedata,
   output logic [31:0]             readdata,
   output logic                    irq,
   output logic [512*NUM_CH-1:0]   core_block,
   output logic [NUM_CH-1:0]       core_start,
   output logic [NUM_CH-1:0]       core_reset,
   input  logic [256*NUM_CH-1:0]   core_digest,
   input  logic [NUM_CH-1:0]       core_done
);

   typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;

   state_t        state_q     [NUM_CH];
   state_t        state_d     [NUM_CH];
   logic [15:0]   load_mask_q [NUM_CH];
   logic [15:0]   load_mask_d [NUM_CH];
   logic          err_q       [NUM_CH];
   logic          err_d       [NUM_CH];
   logic          irq_en_q    [NUM_CH];
   logic          irq_en_d    [NUM_CH];
   logic [511:0]  block_q     [NUM_CH];
   logic [511:0]  block_d     [NUM_CH];
   logic [255:0]  digest_q    [NUM_CH];
   logic [255:0]  digest_d    [NUM_CH];
   logic [NUM_CH-1:0] start_q, start_d;
   logic [NUM_CH-1:0] soft_q, soft_d;
   logic [31:0]   readdata_q, readdata_d;

   logic [AW-1:0] ch_field;
   logic [4:0]    offset;
   logic          in_range;
   logic          wr_en;
   logic          rd_en;

   // Upper address bits select the channel; indices beyond NUM_CH fall out of range.
   assign ch_field = address >> 5;
   assign offset   = address[4:0];
   assign in_range = ch_field < AW'(NUM_CH);
   assign wr_en    = chipselect & write & in_range;
   assign rd_en    = chipselect & read;

   always_comb begin
      logic ch_wr;
      ch_wr = 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
         state_d[c]     = state_q[c];
         load_mask_d[c] = load_mask_q[c];
         err_d[c]       = err_q[c];
         irq_en_d[c]    = irq_en_q[c];
         block_d[c]     = block_q[c];
         digest_d[c]    = digest_q[c];
         start_d[c]     = 1'b0;
         soft_d[c]      = 1'b0;
         ch_wr          = wr_en && (ch_field == AW'(c));

         if (core_done[c] && state_q[c] == ST_BUSY) begin
            state_d[c]  = ST_DONE;
            digest_d[c] = core_digest[256*c +: 256];
         end

         if (ch_wr && !offset[4]) begin
            if (state_q[c] == ST_BUSY) begin
               err_d[c] = 1'b1;
            end else begin
               block_d[c][32*offset[3:0] +: 32] = writedata;
               load_mask_d[c][offset[3:0]]       = 1'b1;
            end
         end

         // Only the highest-priority command in a control write acts: soft_reset, then start, then ack.
         if (ch_wr && offset == 5'd16) begin
            if (writedata[2]) begin
               state_d[c]     = ST_IDLE;
               load_mask_d[c] = '0;
               err_d[c]       = 1'b0;
               irq_en_d[c]    = 1'b0;
               digest_d[c]    = '0;
               soft_d[c]      = 1'b1;
            end else begin
               if (writedata[4]) begin
                  irq_en_d[c] = 1'b0;
               end else if (writedata[3]) begin
                  irq_en_d[c] = 1'b1;
               end
               if (writedata[0]) begin
                  if (state_q[c] == ST_IDLE && load_mask_q[c] == 16'hFFFF) begin
                     state_d[c]     = ST_BUSY;
                     load_mask_d[c] = '0;
                     start_d[c]     = 1'b1;
                  end else begin
                     err_d[c] = 1'b1;
                  end
               end else if (writedata[1] && state_q[c] == ST_DONE) begin
                  state_d[c] = ST_IDLE;
               end
            end
         end
      end
   end

   // Read data is captured from the pre-edge register values, so a same-cycle write is not visible.
   always_comb begin
      readdata_d = readdata_q;
      if (rd_en) begin
         readdata_d = '0;
         for (int c = 0; c < NUM_CH; c++) begin
            if (in_range && ch_field == AW'(c)) begin
               if (offset == 5'd17) begin
                  readdata_d = {load_mask_q[c], 12'b0, irq_en_q[c], err_q[c],
                                state_q[c] == ST_DONE, state_q[c] == ST_BUSY};
               end else if (offset[4:3] == 2'b11) begin
                  readdata_d = digest_q[c][32*offset[2:0] +: 32];
               end
            end
         end
      end
   end

   always_comb begin
      irq = 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
         irq = irq | ((state_q[c] == ST_DONE) & irq_en_q[c]);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int c = 0; c < NUM_CH; c++) begin
            state_q[c]     <= ST_IDLE;
            load_mask_q[c] <= '0;
            err_q[c]       <= 1'b0;
            irq_en_q[c]    <= 1'b0;
            block_q[c]     <= '0;
            digest_q[c]    <= '0;
         end
         start_q    <= '0;
         soft_q     <= '0;
         readdata_q <= '0;
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            state_q[c]     <= state_d[c];
            load_mask_q[c] <= load_mask_d[c];
            err_q[c]       <= err_d[c];
            irq_en_q[c]    <= irq_en_d[c];
            block_q[c]     <= block_d[c];
            digest_q[c]    <= digest_d[c];
         end
         start_q    <= start_d;
         soft_q     <= soft_d;
         readdata_q <= readdata_d;
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_block
      assign core_block[512*g +: 512] = block_q[g];
   end

   assign readdata   = readdata_q;
   assign core_start = start_q;
   assign core_reset = soft_q | {NUM_CH{reset}};

endmodule

// File: tb/tb_sha_acc_mc.sv
// Directed bench for sha_acc_mc: a per-channel behavioural model is checked every cycle,
// and literal expectations from hand calculation pin the model at key points.
module tb_sha_acc_mc;

   localparam int NUM_CH = 4;
   localparam int AW     = 8;

   logic                  clk = 1'b0;
   logic                  reset = 1'b1;
   logic                  chipselect = 1'b0;
   logic                  write = 1'b0;
   logic                  read = 1'b0;
   logic [AW-1:0]         address = '0;
   logic [31:0]           writedata = '0;
   logic [31:0]           readdata;
   logic                  irq;
   logic [512*NUM_CH-1:0] core_block;
   logic [NUM_CH-1:0]     core_start;
   logic [NUM_CH-1:0]     core_reset;
   logic [256*NUM_CH-1:0] core_digest = '0;
   logic [NUM_CH-1:0]     core_done = '0;

   int n_checks = 0;
   int n_pass   = 0;
   int starts_seen [NUM_CH] = '{default: 0};

   sha_acc_mc #(.NUM_CH(NUM_CH), .AW(AW)) dut (
      .clk(clk), .reset(reset), .chipselect(chipselect), .write(write), .read(read),
      .address(address), .writedata(writedata), .readdata(readdata), .irq(irq),
      .core_block(core_block), .core_start(core_start), .core_reset(core_reset),
      .core_digest(core_digest), .core_done(core_done)
   );

   always #5 clk = ~clk;

   // Model: state 0 idle, 1 busy, 2 done
   int          m_state [NUM_CH] = '{default: 0};
   logic [15:0] m_mask  [NUM_CH] = '{default: '0};
   logic        m_err   [NUM_CH] = '{default: 1'b0};
   logic        m_irqen [NUM_CH] = '{default: 1'b0};
   logic [31:0] m_dig   [NUM_CH][8];
   logic [31:0] m_blk   [NUM_CH][16];
   logic [31:0] m_rd    = '0;
   logic [NUM_CH-1:0] m_start = '0;
   logic [NUM_CH-1:0] m_softp = '0;
   logic [511:0] exp_blk;

   function automatic logic [31:0] model_read(input logic [AW-1:0] a);
      int ch;
      int off;
      ch  = int'(a[AW-1:5]);
      off = int'(a[4:0]);
      if (ch >= NUM_CH) return 32'h0;
      if (off == 17)
         return {m_mask[ch], 12'b0, m_irqen[ch], m_err[ch], m_state[ch] == 2, m_state[ch] == 1};
      if (off >= 24) return m_dig[ch][off-24];
      return 32'h0;
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         for (int c = 0; c < NUM_CH; c++) begin
            m_state[c] = 0; m_mask[c] = '0; m_err[c] = 1'b0; m_irqen[c] = 1'b0;
            for (int k = 0; k < 8; k++) m_dig[c][k] = '0;
            for (int k = 0; k < 16; k++) m_blk[c][k] = '0;
         end
         m_rd = '0; m_start = '0; m_softp = '0;
      end else begin
         if (chipselect && read) m_rd = model_read(address);
         m_start = '0;
         m_softp = '0;
         for (int c = 0; c < NUM_CH; c++) begin
            int old;
            int off;
            bit sel;
            old = m_state[c];
            off = int'(address[4:0]);
            sel = chipselect && write && (int'(address[AW-1:5]) == c);
            if (core_done[c] && old == 1) begin
               m_state[c] = 2;
               for (int k = 0; k < 8; k++) m_dig[c][k] = core_digest[256*c + 32*k +: 32];
            end
            if (sel && off < 16) begin
               if (old == 1) m_err[c] = 1'b1;
               else begin
                  m_blk[c][off] = writedata;
                  m_mask[c][off] = 1'b1;
               end
            end
            if (sel && off == 16) begin
               if (writedata[2]) begin
                  m_state[c] = 0; m_mask[c] = '0; m_err[c] = 1'b0; m_irqen[c] = 1'b0;
                  for (int k = 0; k < 8; k++) m_dig[c][k] = '0;
                  m_softp[c] = 1'b1;
               end else begin
                  if (writedata[4]) m_irqen[c] = 1'b0;
                  else if (writedata[3]) m_irqen[c] = 1'b1;
                  if (writedata[0]) begin
                     if (old == 0 && m_mask[c] == 16'hFFFF) begin
                        m_state[c] = 1; m_mask[c] = '0; m_start[c] = 1'b1;
                     end else m_err[c] = 1'b1;
                  end else if (writedata[1] && old == 2) m_state[c] = 0;
               end
            end
         end
      end
   end

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
   endtask

   // Every cycle, compare all DUT outputs against the model on the falling edge.
   always @(negedge clk) begin
      logic m_irq;
      m_irq = 1'b0;
      for (int c = 0; c < NUM_CH; c++) m_irq = m_irq | (m_state[c] == 2 && m_irqen[c]);
      check_output("readdata", readdata, m_rd);
      check_output("irq", {31'b0, irq}, {31'b0, m_irq});
      check_output("core_start", {28'b0, core_start}, {28'b0, m_start});
      check_output("core_reset", {28'b0, core_reset}, {28'b0, (reset ? 4'hF : m_softp)});
      for (int c = 0; c < NUM_CH; c++) begin
         for (int k = 0; k < 16; k++) exp_blk[32*k +: 32] = m_blk[c][k];
         n_checks++;
         if (core_block[512*c +: 512] === exp_blk) n_pass++;
         else $display("[TB] FAIL core_block ch%0d: got %h, expected %h", c, core_block[512*c +: 512], exp_blk);
         if (core_start[c]) starts_seen[c]++;
      end
   end

   function automatic logic [AW-1:0] ad(input int ch, input int off);
      return AW'(ch * 32 + off);
   endfunction

   task automatic wr(input int ch, input int off, input logic [31:0] d);
      chipselect = 1'b1; write = 1'b1; address = ad(ch, off); writedata = d;
      @(posedge clk); #1;
      chipselect = 1'b0; write = 1'b0;
   endtask

   task automatic rd(input int ch, input int off, output logic [31:0] d);
      chipselect = 1'b1; read = 1'b1; address = ad(ch, off);
      @(posedge clk); #1;
      chipselect = 1'b0; read = 1'b0;
      d = readdata;
   endtask

   task automatic load_block(input int ch, input logic [31:0] base);
      for (int k = 0; k < 16; k++) wr(ch, k, base + 32'(k));
   endtask

   task automatic pulse_done(input logic [NUM_CH-1:0] m);
      core_done = m;
      @(posedge clk); #1;
      core_done = '0;
   endtask

   task automatic set_digest(input int ch, input logic [31:0] w [8]);
      for (int k = 0; k < 8; k++) core_digest[256*ch + 32*k +: 32] = w[k];
   endtask

   task automatic apply_stimulus();
      logic [31:0] d;
      logic [31:0] abc_dig [8];
      logic [31:0] dg [8];
      abc_dig = '{32'hBA7816BF, 32'h8F01CFEA, 32'h414140DE, 32'h5DAE2223,
                  32'hB00361A3, 32'h96177A9C, 32'hB410FF61, 32'hF20015AD};

      repeat (3) @(posedge clk);
      #1;
      check_output("reset_core_reset", {28'b0, core_reset}, 32'hF);
      check_output("reset_readdata", readdata, 32'h0);
      reset = 1'b0;
      rd(0, 17, d); check_output("reset_status", d, 32'h0);

      // Single "abc" hash on channel 0
      wr(0, 0, 32'h61626380);
      for (int k = 1; k < 15; k++) wr(0, k, 32'h0);
      wr(0, 15, 32'h00000018);
      rd(0, 17, d); check_output("abc_loaded_status", d, 32'hFFFF0000);
      wr(0, 16, 32'h1);
      check_output("abc_core_start", {28'b0, core_start}, 32'h1);
      rd(0, 17, d); check_output("abc_busy_status", d, 32'h1);
      set_digest(0, abc_dig);
      pulse_done(4'b0001);
      rd(0, 17, d); check_output("abc_done_status", d, 32'h2);
      for (int k = 0; k < 8; k++) begin
         rd(0, 24 + k, d); check_output($sformatf("abc_digest%0d", k), d, abc_dig[k]);
      end
      wr(0, 16, 32'h2);
      rd(0, 17, d); check_output("abc_ack_status", d, 32'h0);

      // Incomplete load then completion
      for (int k = 0; k < 15; k++) wr(0, k, 32'hA0 + 32'(k));
      wr(0, 16, 32'h1);
      check_output("incomplete_no_start", {28'b0, core_start}, 32'h0);
      rd(0, 17, d); check_output("incomplete_status", d, 32'h7FFF0004);
      wr(0, 15, 32'hAF);
      wr(0, 16, 32'h1);
      check_output("retry_core_start", {28'b0, core_start}, 32'h1);
      rd(0, 17, d); check_output("retry_status", d, 32'h5);
      pulse_done(4'b0001);
      wr(0, 16, 32'h2);

      // Busy protection on channel 2
      load_block(2, 32'h2000);
      wr(2, 16, 32'h1);
      wr(2, 3, 32'hDEADBEEF);
      wr(2, 16, 32'h1);
      rd(2, 17, d); check_output("busy_prot_status", d, 32'h5);
      check_output("busy_prot_word3", core_block[512*2 + 32*3 +: 32], 32'h2003);
      pulse_done(4'b0100);
      wr(2, 16, 32'h2);

      // Channels 1 and 3 finish together; only channel 1 has irq_en
      wr(1, 16, 32'h8);
      load_block(1, 32'h1000);
      load_block(3, 32'h3000);
      wr(1, 16, 32'h1);
      wr(3, 16, 32'h1);
      for (int k = 0; k < 8; k++) dg[k] = 32'h11110000 + 32'(k);
      set_digest(1, dg);
      for (int k = 0; k < 8; k++) dg[k] = 32'h33330000 + 32'(k);
      set_digest(3, dg);
      check_output("multi_irq_before", {31'b0, irq}, 32'h0);
      pulse_done(4'b1010);
      check_output("multi_irq_after", {31'b0, irq}, 32'h1);
      rd(1, 17, d); check_output("multi_ch1_status", d, 32'hA);
      rd(3, 17, d); check_output("multi_ch3_status", d, 32'h2);
      rd(1, 24, d); check_output("multi_ch1_digest0", d, 32'h11110000);
      rd(3, 31, d); check_output("multi_ch3_digest7", d, 32'h33330007);
      wr(1, 16, 32'h2);
      check_output("multi_irq_acked", {31'b0, irq}, 32'h0);
      wr(3, 16, 32'h2);

      // Soft reset on channel 3 coinciding with core_done
      load_block(3, 32'h3100);
      wr(3, 16, 32'h1);
      core_done = 4'b1000;
      wr(3, 16, 32'h4);
      core_done = '0;
      check_output("soft_core_reset", {28'b0, core_reset}, 32'h8);
      rd(3, 17, d); check_output("soft_status", d, 32'h0);
      rd(3, 24, d); check_output("soft_digest0", d, 32'h0);
      check_output("soft_irq", {31'b0, irq}, 32'h0);
      check_output("soft_block_kept", core_block[512*3 +: 32], 32'h3100);
      rd(1, 25, d); check_output("ch1_digest_untouched", d, 32'h11110001);

      // Unmapped offsets and out-of-range channels
      wr(5, 0, 32'h12345678);
      wr(5, 16, 32'h1);
      wr(4, 16, 32'h8);
      wr(0, 20, 32'hFFFFFFFF);
      rd(0, 17, d); check_output("unmapped_pre_status", d, 32'h4);
      rd(0, 20, d); check_output("unmapped_off20", d, 32'h0);
      rd(0, 17, d);
      rd(5, 17, d); check_output("range_ch5_status", d, 32'h0);
      rd(5, 24, d); check_output("range_ch5_digest", d, 32'h0);

      repeat (2) @(posedge clk);
      #1;
      check_output("starts_ch0", 32'(starts_seen[0]), 32'd2);
      check_output("starts_ch1", 32'(starts_seen[1]), 32'd1);
      check_output("starts_ch2", 32'(starts_seen[2]), 32'd1);
      check_output("starts_ch3", 32'(starts_seen[3]), 32'd2);
   endtask

   initial begin
      apply_stimulus();
      @(posedge clk); #1;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
